dynamics_multi: RTL and testbench

Multi-channel dynamics processor: the parametrised successor to the single-channel `dynamics` gain block. It accepts one frame of `CHANNELS` signed samples via a valid/ready handshake and tracks a shared peak envelope. It derives a target gain from a threshold and mode (bypass, compressor, gate), slews the applied gain with attack/release shifts, and emits the scaled frame. It sits in the audio path between the sample source/mixer and the output codec interface.

---
 rtl/dynamics_pkg.sv | 30 +++
 rtl/dynamics_gain_ctrl.sv | 78 +++++++
 rtl/dynamics_multi.sv | 170 +++++++++++++++++
 tb/tb_dynamics_multi.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dynamics_pkg.sv
// Shared definitions for the multi-channel dynamics processor.
// Mode encodings, unity gain, FSM states and the gain slew step helper.
package dynamics_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_COMP   = 2'b01;
    localparam logic [1:0] MODE_GATE   = 2'b10;

    localparam logic [7:0] UNITY_GAIN = 8'd128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PEAK  = 3'd1,
        ST_ENV   = 3'd2,
        ST_GAIN  = 3'd3,
        ST_APPLY = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Slew step: the shifted gap, but never less than one code.
    function automatic logic [7:0] slew_step(
        input logic [7:0] diff,
        input logic [2:0] sh
    );
        logic [7:0] s;
        s = diff >> sh;
        return (s == 8'd0) ? 8'd1 : s;
    endfunction

endpackage

// File: rtl/dynamics_gain_ctrl.sv
// Envelope tracker and gain computer for the dynamics processor.
// Updates the envelope on env_en and the slewed gain on gain_en.
module dynamics_gain_ctrl
    import dynamics_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DECAY_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              env_en,
    input  logic              gain_en,
    input  logic [DATA_W-2:0] peak,
    input  logic [1:0]        mode,
    input  logic [DATA_W-2:0] threshold,
    input  logic [1:0]        ratio_shift,
    input  logic [2:0]        attack_shift,
    input  logic [2:0]        release_shift,
    output logic [7:0]        gain
);

    logic [DATA_W-2:0] env;
    logic [DATA_W-2:0] excess;
    logic [DATA_W-2:0] red_full;
    logic [7:0]        red;
    logic [7:0]        target;
    logic [7:0]        gain_nxt;

    // Target gain for the current envelope and mode.
    always_comb begin
        excess   = (env > threshold) ? (env - threshold) : '0;
        red_full = (excess >> (DATA_W - 8)) >> ratio_shift;
        red      = red_full[7:0];
        target   = UNITY_GAIN;
        unique case (mode)
            MODE_COMP: begin
                if (red >= UNITY_GAIN)
                    target = 8'd1;
                else
                    target = UNITY_GAIN - red;
            end
            MODE_GATE: begin
                target = (env < threshold) ? 8'd0 : UNITY_GAIN;
            end
            default: target = UNITY_GAIN;
        endcase
    end

    // Slew toward target; a step never exceeds the gap, so no overshoot.
    always_comb begin
        gain_nxt = gain;
        if (target < gain)
            gain_nxt = gain - slew_step(gain - target, attack_shift);
        else if (target > gain)
            gain_nxt = gain + slew_step(target - gain, release_shift);
    end

    // Peak-hold envelope with exponential decay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            env <= '0;
        else if (env_en) begin
            if (peak >= env)
                env <= peak;
            else
                env <= env - (env >> DECAY_SHIFT);
        end
    end

    // Applied gain register, persists across frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gain <= UNITY_GAIN;
        else if (gain_en)
            gain <= gain_nxt;
    end

endmodule

// File: rtl/dynamics_multi.sv
// Multi-channel dynamics processor top level.
// Serial peak detect, shared gain control, one shared multiplier.
module dynamics_multi
    import dynamics_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int CHANNELS    = 2,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*DATA_W-1:0] sample_in,
    input  logic [1:0]                 mode,
    input  logic [DATA_W-2:0]          threshold,
    input  logic [1:0]                 ratio_shift,
    input  logic [2:0]                 attack_shift,
    input  logic [2:0]                 release_shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHANNELS*DATA_W-1:0] sample_out,
    output logic [7:0]                 gain_out,
    output logic                       gr_active
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = CHANNELS * DATA_W;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
    localparam logic [DATA_W-2:0] MAG_MAX = '1;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]     ch;
    logic              last_ch;
    logic              accept;
    logic [FW-1:0]     frame_q;
    logic [1:0]        mode_q;
    logic [DATA_W-2:0] thr_q;
    logic [1:0]        ratio_q;
    logic [2:0]        att_q;
    logic [2:0]        rel_q;
    logic [DATA_W-2:0] peak;
    logic [7:0]        gain;

    logic signed [DATA_W-1:0] x;
    logic        [DATA_W-1:0] neg_x;
    logic        [DATA_W-2:0] mag;
    logic signed [DATA_W+8:0] prod;
    logic signed [DATA_W-1:0] scaled;
    logic                     prod_unused;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign last_ch   = (ch == LAST_CH);
    assign gain_out  = gain;
    assign gr_active = (gain < UNITY_GAIN);

    // Current channel sample, its saturated magnitude and scaled value.
    always_comb begin
        x     = frame_q[int'(ch)*DATA_W +: DATA_W];
        neg_x = -x;
        if (!x[DATA_W-1])
            mag = x[DATA_W-2:0];
        else if (x == MOST_NEG)
            mag = MAG_MAX;
        else
            mag = neg_x[DATA_W-2:0];
        prod   = x * $signed({1'b0, gain});
        scaled = prod[DATA_W+6:7];
    end

    assign prod_unused = ^{prod[DATA_W+8:DATA_W+7], prod[6:0], neg_x[DATA_W-1]};

    // Frame sequencing.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = ST_PEAK;
            ST_PEAK:  if (last_ch) state_nxt = ST_ENV;
            ST_ENV:   state_nxt = ST_GAIN;
            ST_GAIN:  state_nxt = ST_APPLY;
            ST_APPLY: if (last_ch) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Channel counter walks the frame in PEAK and again in APPLY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ch <= '0;
        else if (state == ST_PEAK || state == ST_APPLY)
            ch <= last_ch ? '0 : ch + 1'b1;
        else
            ch <= '0;
    end

    // Frame and configuration captured only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            mode_q  <= MODE_BYPASS;
            thr_q   <= '0;
            ratio_q <= '0;
            att_q   <= '0;
            rel_q   <= '0;
        end else if (accept) begin
            frame_q <= sample_in;
            mode_q  <= mode;
            thr_q   <= threshold;
            ratio_q <= ratio_shift;
            att_q   <= attack_shift;
            rel_q   <= release_shift;
        end
    end

    // Running peak magnitude across the frame's channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            peak <= '0;
        else if (accept)
            peak <= '0;
        else if (state == ST_PEAK && mag > peak)
            peak <= mag;
    end

    // Scaled samples land per channel; valid rises with the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (state == ST_APPLY)
                sample_out[int'(ch)*DATA_W +: DATA_W] <= scaled;
            if (state == ST_APPLY && last_ch)
                out_valid <= 1'b1;
            else if (out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

    dynamics_gain_ctrl #(
        .DATA_W      (DATA_W),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_gain_ctrl (
        .clk           (clk),
        .rst           (rst),
        .env_en        (state == ST_ENV),
        .gain_en       (state == ST_GAIN),
        .peak          (peak),
        .mode          (mode_q),
        .threshold     (thr_q),
        .ratio_shift   (ratio_q),
        .attack_shift  (att_q),
        .release_shift (rel_q),
        .gain          (gain)
    );

endmodule

// File: tb/tb_dynamics_multi.sv
// Bench for dynamics_multi: two instances (decay 0 and 4) in lock-step
// against a frame-level reference model plus directed spot values.
module tb_dynamics_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] sample_in = '0;
    logic [1:0]  mode = '0;
    logic [14:0] threshold = '0;
    logic [1:0]  ratio_shift = '0;
    logic [2:0]  attack_shift = '0;
    logic [2:0]  release_shift = '0;
    logic        out_ready = 1'b1;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] sample_out0, sample_out1;
    logic [7:0]  gain_out0, gain_out1;
    logic        gr_active0, gr_active1;

    int checks = 0;
    int errors = 0;

    int m_env[2];
    int m_gain[2];
    int m_decay[2] = '{0, 4};
    int exp_s[2][2];

    always #5 clk = ~clk;

    dynamics_multi #(.DATA_W(16), .CHANNELS(2), .DECAY_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .sample_in(sample_in), .mode(mode), .threshold(threshold),
        .ratio_shift(ratio_shift), .attack_shift(attack_shift),
        .release_shift(release_shift), .out_valid(out_valid0),
        .out_ready(out_ready), .sample_out(sample_out0),
        .gain_out(gain_out0), .gr_active(gr_active0)
    );

    dynamics_multi #(.DATA_W(16), .CHANNELS(2), .DECAY_SHIFT(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .sample_in(sample_in), .mode(mode), .threshold(threshold),
        .ratio_shift(ratio_shift), .attack_shift(attack_shift),
        .release_shift(release_shift), .out_valid(out_valid1),
        .out_ready(out_ready), .sample_out(sample_out1),
        .gain_out(gain_out1), .gr_active(gr_active1)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ch_val(input logic [31:0] f, input int c);
        logic [15:0] w;
        w = (c == 0) ? f[15:0] : f[31:16];
        return int'($signed(w));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_env[d]  = 0;
            m_gain[d] = 128;
        end
    endtask

    // One frame through the reference rules, for both decay settings.
    task automatic model_step(input int s0, input int s1, input int md,
                              input int thr, input int rs, input int as_,
                              input int rls);
        int s[2];
        int a, pk, ex, red, tgt, st, g;
        s[0] = s0;
        s[1] = s1;
        for (int d = 0; d < 2; d++) begin
            pk = 0;
            for (int c = 0; c < 2; c++) begin
                a = (s[c] < 0) ? -s[c] : s[c];
                if (a > 32767) a = 32767;
                if (a > pk) pk = a;
            end
            if (pk >= m_env[d]) m_env[d] = pk;
            else m_env[d] = m_env[d] - (m_env[d] >> m_decay[d]);
            if (md == 1) begin
                ex = m_env[d] - thr;
                if (ex < 0) ex = 0;
                red = (ex / 256) / (1 << rs);
                tgt = 128 - red;
                if (tgt < 1) tgt = 1;
            end else if (md == 2) begin
                tgt = (m_env[d] < thr) ? 0 : 128;
            end else begin
                tgt = 128;
            end
            g = m_gain[d];
            if (tgt < g) begin
                st = (g - tgt) >> as_;
                if (st < 1) st = 1;
                g = g - st;
                if (g < tgt) g = tgt;
            end else if (tgt > g) begin
                st = (tgt - g) >> rls;
                if (st < 1) st = 1;
                g = g + st;
                if (g > tgt) g = tgt;
            end
            m_gain[d] = g;
            for (int c = 0; c < 2; c++)
                exp_s[d][c] = (s[c] * g) >>> 7;
        end
    endtask

    task automatic run_frame(input int s0, input int s1, input int md,
                             input int thr, input int rs, input int as_,
                             input int rls, input int bp);
        int n;
        int lat;
        logic [31:0] hold0;
        model_step(s0, s1, md, thr, rs, as_, rls);
        @(negedge clk);
        sample_in     = {16'(s1), 16'(s0)};
        mode          = 2'(md);
        threshold     = 15'(thr);
        ratio_shift   = 2'(rs);
        attack_shift  = 3'(as_);
        release_shift = 3'(rls);
        out_ready     = (bp == 0);
        in_valid      = 1'b1;
        n = 0;
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready", int'(in_ready0), 1);
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        sample_in     = $urandom;
        mode          = 2'($urandom);
        threshold     = 15'($urandom);
        ratio_shift   = 2'($urandom);
        attack_shift  = 3'($urandom);
        release_shift = 3'($urandom);
        lat = 0;
        while (!out_valid0 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 6);
        if (bp > 0) begin
            hold0 = sample_out0;
            repeat (bp) begin
                @(negedge clk);
                in_valid = 1'($urandom_range(0, 1));
                check("bp_hold", int'(sample_out0), int'(hold0));
                check("bp_in_ready", int'(in_ready0), 0);
                check("bp_out_valid", int'(out_valid0), 1);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        check("d0_ch0", ch_val(sample_out0, 0), exp_s[0][0]);
        check("d0_ch1", ch_val(sample_out0, 1), exp_s[0][1]);
        check("d0_gain", int'(gain_out0), m_gain[0]);
        check("d0_gr", int'(gr_active0), int'(m_gain[0] < 128));
        check("d1_ch0", ch_val(sample_out1, 0), exp_s[1][0]);
        check("d1_ch1", ch_val(sample_out1, 1), exp_s[1][1]);
        check("d1_gain", int'(gain_out1), m_gain[1]);
        check("d1_valid", int'(out_valid1), 1);
        @(posedge clk);
        #1;
        check("xfer_done", int'(out_valid0), 0);
    endtask

    function automatic int rand_sample();
        int k;
        k = int'($urandom_range(0, 3));
        if (k == 0) return int'($urandom_range(0, 1024)) - 512;
        if (k == 1) return -32768;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            run_frame(rand_sample(), rand_sample(),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 32767)) >> $urandom_range(0, 4),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    endtask

    initial begin
        int n;
        bit seen;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid0), 0);
        check("rst_sample_out", int'(sample_out0), 0);
        check("rst_gain", int'(gain_out0), 128);
        check("rst_gr", int'(gr_active0), 0);
        check("rst_in_ready", int'(in_ready0), 0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", int'(in_ready0), 1);

        run_random(30);

        // Abort a frame with a 3-cycle reset in the middle.
        @(negedge clk);
        sample_in    = {16'h7000, 16'h7000};
        mode         = 2'b01;
        threshold    = 15'h0010;
        attack_shift = 3'd0;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        n = 0;
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_out_valid", int'(out_valid0), 0);
        check("abort_gain0", int'(gain_out0), 128);
        check("abort_gain1", int'(gain_out1), 128);
        check("abort_in_ready", int'(in_ready0), 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("abort_ready_after", int'(in_ready0), 1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) seen = 1'b1;
        end
        check("abort_no_frame", int'(seen), 0);

        // Bypass.
        run_frame(16'sh1555, -16'sh1555, 0, 0, 0, 0, 0, 0);
        check("byp_ch0", ch_val(sample_out0, 0), 'h1555);
        check("byp_ch1", ch_val(sample_out0, 1), -'h1555);
        check("byp_gain", int'(gain_out0), 128);

        // Compressor attack.
        run_frame('h5000, 'h5000, 1, 'h1000, 1, 0, 2, 0);
        check("comp_gain", int'(gain_out0), 96);
        check("comp_ch0", ch_val(sample_out0, 0), 'h3C00);
        check("comp_ch1", ch_val(sample_out0, 1), 'h3C00);
        check("comp_gr", int'(gr_active0), 1);

        // Release with zero frames.
        run_frame(0, 0, 1, 'h1000, 1, 0, 2, 0);
        check("rel_gain1", int'(gain_out0), 104);
        run_frame(0, 0, 1, 'h1000, 1, 0, 2, 0);
        check("rel_gain2", int'(gain_out0), 110);
        run_frame(0, 0, 1, 'h1000, 1, 0, 2, 0);
        check("rel_gain3", int'(gain_out0), 114);
        run_frame(0, 0, 1, 'h1000, 1, 0, 2, 0);
        check("rel_gain4", int'(gain_out0), 117);

        // Gate closes then opens.
        run_frame('h50, 'h50, 2, 'h100, 0, 0, 3, 0);
        check("gate_gain0", int'(gain_out0), 0);
        check("gate_out0", ch_val(sample_out0, 0), 0);
        run_frame(-32768, 0, 2, 'h100, 0, 0, 0, 0);
        check("gate_gain128", int'(gain_out0), 128);
        check("gate_neg", ch_val(sample_out0, 0), -32768);
        check("gate_zero", ch_val(sample_out0, 1), 0);

        // Backpressure.
        run_frame('h2345, -'h1234, 1, 'h0800, 2, 1, 1, 5);

        run_random(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
